// File: rtl/seg_scan_drv_pkg.sv
// rtl/seg_scan_drv_pkg.sv - shared types and constants for the seven-segment scan driver
package seg_scan_drv_pkg;

  typedef enum logic {
    ST_GAP,
    ST_ON
  } state_t;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
    logic [3:0]  blank;
  } frame_t;

  localparam logic [7:0] SEG_OFF = 8'hFF;
  localparam logic [3:0] AN_OFF  = 4'hF;

  // Active-low {g,f,e,d,c,b,a}, entry 15 first
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };

endpackage

// File: rtl/seg_scan_drv_hex7seg.sv
// rtl/seg_scan_drv_hex7seg.sv - combinational hex digit to active-low segment decoder
module hex7seg
  import seg_scan_drv_pkg::*;
(
  input  logic [3:0] hex,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[hex];

endmodule

// File: rtl/seg_scan_drv.sv
// rtl/seg_scan_drv.sv - four-digit multiplexed seven-segment scan driver with frame-synchronous update
module seg_scan_drv
  import seg_scan_drv_pkg::*;
#(
  parameter int DWELL = 50000,
  parameter int GAP   = 500
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [15:0] data,
  input  logic [3:0]  dp,
  input  logic [3:0]  blank,
  output logic        ready,
  output logic [3:0]  AN,
  output logic [7:0]  SEGMENT,
  output logic        frame_sync
);

  localparam int MAXC = (DWELL > GAP) ? DWELL : GAP;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL - 1);
  localparam logic [CW-1:0] GAP_LAST   = (GAP > 0) ? CW'(GAP - 1) : '0;
  localparam state_t        SLOT_START = (GAP == 0) ? ST_ON : ST_GAP;

  state_t          state, state_n;
  logic [1:0]      d, d_n;
  logic [CW-1:0]   cnt, cnt_n;
  frame_t          pending, pending_n;
  frame_t          shadow, shadow_n;
  logic            ready_n;
  logic            boundary;
  logic [3:0]      hex;
  logic [6:0]      seg7;
  logic [3:0]      an_n;
  logic [7:0]      seg_n;
  logic            sync_n;

  always_comb begin
    state_n  = state;
    d_n      = d;
    cnt_n    = cnt + 1'b1;
    boundary = 1'b0;
    unique case (state)
      ST_GAP: begin
        if (cnt == GAP_LAST) begin
          state_n = ST_ON;
          cnt_n   = '0;
        end
      end
      ST_ON: begin
        if (cnt == DWELL_LAST) begin
          state_n  = SLOT_START;
          cnt_n    = '0;
          d_n      = d + 2'd1;
          boundary = (d == 2'd3);
        end
      end
    endcase
  end

  // A full pending frame drains only at the boundary; a boundary load with an
  // empty pending register is simply captured and waits for the next one.
  always_comb begin
    pending_n = (load && ready) ? {data, dp, blank} : pending;
    shadow_n  = (boundary && !ready) ? pending : shadow;
    ready_n   = ready ? !load : boundary;
  end

  assign hex = shadow_n.data[{d_n, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .hex (hex),
    .seg (seg7)
  );

  // Outputs are decoded from next-state values so the registered pins line up
  // with the scan state rather than lagging it by a cycle.
  always_comb begin
    an_n  = AN_OFF;
    seg_n = SEG_OFF;
    if (state_n == ST_ON) begin
      an_n[d_n] = 1'b0;
      if (!shadow_n.blank[d_n]) begin
        seg_n = {~shadow_n.dp[d_n], seg7};
      end
    end
    sync_n = (state_n == ST_ON) && (d_n == 2'd3) && (cnt_n == DWELL_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= SLOT_START;
      d          <= 2'd0;
      cnt        <= '0;
      pending    <= '0;
      shadow     <= '0;
      ready      <= 1'b1;
      AN         <= AN_OFF;
      SEGMENT    <= SEG_OFF;
      frame_sync <= 1'b0;
    end else begin
      state      <= state_n;
      d          <= d_n;
      cnt        <= cnt_n;
      pending    <= pending_n;
      shadow     <= shadow_n;
      ready      <= ready_n;
      AN         <= an_n;
      SEGMENT    <= seg_n;
      frame_sync <= sync_n;
    end
  end

endmodule

// File: tb/tb_seg_scan_drv.sv
// tb/tb_seg_scan_drv.sv - directed scoreboard bench for seg_scan_drv with DWELL=4, GAP=2
module tb_seg_scan_drv;

  localparam int DWELL_C = 4;
  localparam int GAP_C   = 2;
  localparam int SLOT    = DWELL_C + GAP_C;
  localparam int FRAME   = 4 * SLOT;

  localparam logic [7:0] HEX_SEG [16] = '{
    8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
    8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
  };

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [15:0] data;
  logic [3:0]  dp;
  logic [3:0]  blank;
  logic        ready;
  logic [3:0]  an;
  logic [7:0]  segment;
  logic        frame_sync;

  int n_cmp  = 0;
  int n_fail = 0;
  logic [31:0] exp_q [$];

  always #5 clk = ~clk;

  seg_scan_drv #(.DWELL(DWELL_C), .GAP(GAP_C)) dut (
    .clk        (clk),
    .rst        (rst),
    .load       (load),
    .data       (data),
    .dp         (dp),
    .blank      (blank),
    .ready      (ready),
    .AN         (an),
    .SEGMENT    (segment),
    .frame_sync (frame_sync)
  );

  function automatic logic [31:0] frame_exp(input logic [15:0] dat, input logic [3:0] pnt,
                                            input logic [3:0] blk);
    logic [31:0] r;
    logic [7:0]  s;
    r = '0;
    for (int i = 0; i < 4; i++) begin
      s    = HEX_SEG[dat[4*i +: 4]];
      s[7] = ~pnt[i];
      if (blk[i]) s = 8'hFF;
      r[8*i +: 8] = s;
    end
    return r;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Called at the negedge of cycle 0 of a frame; leaves at cycle 0 of the next.
  task automatic check_frame(input int ka, input logic [23:0] fa, input int kb,
                             input logic [23:0] fb, input logic rdy_end);
    logic [31:0] e;
    logic [7:0]  es;
    logic [3:0]  ea;
    int          dg;
    n_cmp++;
    assert (exp_q.size() != 0) else begin
      n_fail++;
      $error("FAIL scoreboard: observed empty queue expected a frame");
    end
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else                   e = 32'hFFFF_FFFF;
    for (int k = 0; k < FRAME; k++) begin
      dg = k / SLOT;
      if ((k % SLOT) < GAP_C) begin
        ea = 4'hF;
        es = 8'hFF;
      end else begin
        ea = ~(4'b0001 << dg);
        es = e[8*dg +: 8];
      end
      chk($sformatf("an k%0d", k), {4'h0, an}, {4'h0, ea});
      chk($sformatf("segment k%0d", k), segment, es);
      chk($sformatf("frame_sync k%0d", k), {7'h0, frame_sync}, {7'h0, (k == FRAME - 1)});
      if (k == FRAME - 1) chk("ready at boundary", {7'h0, ready}, {7'h0, rdy_end});
      load = (k == ka) || (k == kb);
      {data, dp, blank} = (k == kb) ? fb : fa;
      @(negedge clk);
    end
    load = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    load  = 1'b0;
    data  = '0;
    dp    = '0;
    blank = '0;
    repeat (3) @(negedge clk);
    chk("reset an", {4'h0, an}, 8'h0F);
    chk("reset segment", segment, 8'hFF);
    chk("reset ready", {7'h0, ready}, 8'h01);
    chk("reset frame_sync", {7'h0, frame_sync}, 8'h00);
    rst = 1'b0;

    // idle scan of the all-zero shadow
    exp_q.push_back(frame_exp(16'h0000, 4'h0, 4'h0));
    exp_q.push_back(frame_exp(16'h0000, 4'h0, 4'h0));
    check_frame(-1, 24'h0, -1, 24'h0, 1'b1);
    check_frame(-1, 24'h0, -1, 24'h0, 1'b1);

    // load, then a second load while busy that must be ignored
    exp_q.push_back(frame_exp(16'h0000, 4'h0, 4'h0));
    exp_q.push_back(frame_exp(16'h8F10, 4'b0010, 4'h0));
    check_frame(0, {16'h8F10, 4'b0010, 4'h0}, 10, {16'h1234, 4'hF, 4'h0}, 1'b0);

    // load on the frame_sync cycle lands one boundary later
    exp_q.push_back(frame_exp(16'h8F10, 4'b0010, 4'h0));
    exp_q.push_back(frame_exp(16'hABCD, 4'h0, 4'h0));
    check_frame(FRAME - 1, {16'hABCD, 4'h0, 4'h0}, -1, 24'h0, 1'b1);
    check_frame(-1, 24'h0, -1, 24'h0, 1'b0);

    // blanked digit 2 with its decimal point requested
    exp_q.push_back(frame_exp(16'h0800, 4'b0100, 4'b0100));
    check_frame(0, {16'h0800, 4'b0100, 4'b0100}, -1, 24'h0, 1'b0);
    check_frame(FRAME - 4, {16'h5555, 4'h0, 4'h0}, -1, 24'h0, 1'b0);

    // frame of 5s with 7s pending; reset lands in digit 2 ON
    for (int k = 0; k < 2 * SLOT + GAP_C; k++) begin
      load = (k == 2);
      {data, dp, blank} = {16'h7777, 4'h0, 4'h0};
      @(negedge clk);
    end
    load = 1'b0;
    chk("digit2 an", {4'h0, an}, 8'h0B);
    chk("digit2 segment", segment, 8'h92);
    chk("digit2 ready", {7'h0, ready}, 8'h00);
    rst = 1'b1;
    @(negedge clk);
    chk("mid reset an", {4'h0, an}, 8'h0F);
    chk("mid reset segment", segment, 8'hFF);
    chk("mid reset ready", {7'h0, ready}, 8'h01);
    chk("mid reset frame_sync", {7'h0, frame_sync}, 8'h00);
    rst = 1'b0;

    exp_q.push_back(frame_exp(16'h0000, 4'h0, 4'h0));
    exp_q.push_back(frame_exp(16'h0000, 4'h0, 4'h0));
    check_frame(-1, 24'h0, -1, 24'h0, 1'b1);
    check_frame(-1, 24'h0, -1, 24'h0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/seg_scan_drv.md
SEG_SCAN_DRV -- requirements
Module: seg_scan_drv

Interface
REQ-001 The block SHALL have a parameter DWELL, default 50000, giving the clock cycles each digit is lit (legal range 1 or more).
REQ-002 The block SHALL have a parameter GAP, default 500, giving the all-off cycles before each digit (0 means no gap).
REQ-003 Port clk, input, width 1: the single clock; all logic is on its rising edge.
REQ-004 Port rst, input, width 1: synchronous, active-high reset.
REQ-005 Port load, input, width 1: frame write strobe, accepted only when ready=1.
REQ-006 Port data, input, width 16: four hex digits; digit d is data[4d+3:4d].
REQ-007 Port dp, input, width 4: decimal-point enable per digit, 1 = lit.
REQ-008 Port blank, input, width 4: digit blank per digit, 1 = segments off.
REQ-009 Port ready, output, width 1: pending register is free.
REQ-010 Port AN, output, width 4: digit anodes, active-low; AN[d] drives digit d.
REQ-011 Port SEGMENT, output, width 8: active-low segments {dp,g,f,e,d,c,b,a}.
REQ-012 Port frame_sync, output, width 1: one-cycle pulse at each frame boundary.

Function
REQ-013 The block SHALL cycle digit index d through 0,1,2,3,0 and so on; each slot is GAP cycles of state GAP followed by DWELL cycles of state ON, so one frame is 4*(GAP+DWELL) cycles.
REQ-014 State GAP: AN=4'b1111 and SEGMENT=8'hFF.
REQ-015 State ON: AN[d]=0 with all other AN bits 1, and SEGMENT is the decode of the shadow digit d.
REQ-016 Transitions: GAP to ON when the cycle counter reaches GAP-1; ON to the next digit's GAP (or its ON when GAP=0) when the counter reaches DWELL-1; the counter clears on every transition.
REQ-017 Decode: SEGMENT[6:0] is the active-low hex pattern and SEGMENT[7]=~dp_sh[d]; examples with dp off: 0 gives C0, 1 gives F9, 8 gives 80, A gives 88, F gives 8E.
REQ-018 When blank_sh[d]=1, SEGMENT SHALL be 8'hFF during ON, including the decimal point.
REQ-019 Handshake: when load=1 and ready=1, {data,dp,blank} SHALL be captured into the pending register and ready SHALL be 0 from the next cycle.
REQ-020 load while ready=0 SHALL be ignored, with no state change.
REQ-021 Frame boundary: the cycle on which digit 3's ON ends. On that cycle the pending register, if full, moves to the shadow register, ready returns to 1 on the next cycle, and frame_sync=1 for exactly that cycle.
REQ-022 Simultaneous load with ready=1 on a boundary cycle: the data is captured into pending and displayed from the following boundary.
REQ-023 The shadow register SHALL change only at a boundary, so a frame never mixes old and new digits.
REQ-024 All outputs SHALL be registered, with no combinational path from inputs to outputs.

Reset
REQ-025 While rst=1 the block SHALL hold AN=4'b1111, SEGMENT=8'hFF, ready=1, frame_sync=0, d=0, state GAP (ON if GAP=0), counter 0, and pending and shadow registers all zero.
REQ-026 Reset asserted mid-slot or mid-frame SHALL abort the frame and discard pending data.
REQ-027 The first cycle after rst falls SHALL be cycle 0 of digit 0's slot.

Structure
REQ-028 A shared package SHALL hold the state enum (GAP, ON), the 16-entry active-low segment table, and the constants SEG_OFF=8'hFF and AN_OFF=4'hF.
REQ-029 The hex-to-segment decoder SHALL be a separate combinational sub-module hex7seg (4-bit in, 7-bit active-low out), instantiated once and fed by a digit mux.
REQ-030 Counter width SHALL be clog2 of max(DWELL,GAP), rounded up to at least 1.

Verification (DWELL=4, GAP=2, 24-cycle frame)
REQ-031 Release reset, no load -> every ON slot shows SEGMENT=C0 on AN=E,D,B,7 in turn; frame_sync pulses every 24 cycles.
REQ-032 load with data=16'h8F10, dp=4'b0010, blank=0 -> after the next boundary digits 0..3 show C0, 79, 8E, 80; ready is low until that boundary.
REQ-033 A second load while ready=0 -> ignored; the displayed frame matches the first load only.
REQ-034 load on the exact frame_sync cycle -> shadow is unchanged that frame and updates at the following boundary.
REQ-035 blank=4'b0100 with dp[2]=1 -> digit 2 ON shows SEGMENT=FF while AN=4'b1011.
REQ-036 rst pulsed during digit 2 ON -> the next cycle shows AN=F, SEGMENT=FF, ready=1, and the scan restarts at digit 0 with pending data dropped.
